// File: rtl/check_node_minsum_serial.sv
// check_node_minsum_serial
//   Serial min-sum check-node unit. Collects DEG sign-magnitude
//   variable-to-check messages (one per handshake), tracking the smallest
//   magnitude with its index, the second smallest magnitude and the XOR of
//   all signs. It then emits DEG check-to-variable messages, one per
//   handshake, with an optional saturating offset on the magnitudes.
// Ports
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   in_valid/in_ready   input handshake; in_msg = {sign, magnitude[MW-1:0]}
//   out_valid/out_ready output handshake; out_msg same format as in_msg
//   out_index           edge index 0..DEG-1 of out_msg
//   out_last            out_msg is edge DEG-1
module check_node_minsum_serial #(
  parameter int DEG    = 4,
  parameter int IDXW   = $clog2(DEG),
  parameter int MW     = 6,
  parameter int OFFSET = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [MW:0]     in_msg,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [MW:0]     out_msg,
  output logic [IDXW-1:0] out_index,
  output logic            out_last
);

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t          state, state_nxt;
  logic [IDXW-1:0] cnt;
  logic [MW-1:0]   min1, min2;
  logic [IDXW-1:0] min1_idx;
  logic            sgn_acc;
  logic [DEG-1:0]  sign_r;

  logic            in_fire, out_fire, cnt_last;
  logic [MW-1:0]   m;
  logic            s;
  logic [MW-1:0]   sel_mag, mag_out;
  logic [MW:0]     diff;

  assign m        = in_msg[MW-1:0];
  assign s        = in_msg[MW];
  assign cnt_last = (cnt == IDXW'(DEG-1));
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (in_fire && cnt_last)  state_nxt = EMIT;
      EMIT:    if (out_fire && cnt_last) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      min1     <= '1;
      min2     <= '1;
      min1_idx <= '0;
      sgn_acc  <= 1'b0;
      sign_r   <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_fire) begin
            sign_r[cnt] <= s;
            sgn_acc     <= sgn_acc ^ s;
            // Strict compares: ties keep the earlier entry
            if (m < min1) begin
              min2     <= min1;
              min1     <= m;
              min1_idx <= cnt;
            end else if (m < min2) begin
              min2 <= m;
            end
            cnt <= cnt_last ? '0 : cnt + 1'b1;
          end
        end
        EMIT: begin
          if (out_fire) begin
            if (cnt_last) begin
              cnt      <= '0;
              min1     <= '1;
              min2     <= '1;
              min1_idx <= '0;
              sgn_acc  <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Outputs depend only on registered state, so out_msg holds steady
  // for as long as the downstream stalls.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_msg   = '0;
    out_index = '0;
    out_last  = 1'b0;
    sel_mag   = '0;
    diff      = '0;
    mag_out   = '0;
    case (state)
      COLLECT: in_ready = 1'b1;
      EMIT: begin
        out_valid = 1'b1;
        sel_mag   = (cnt == min1_idx) ? min2 : min1;
        // One extra bit so an oversized offset shows up as a borrow
        diff      = {1'b0, sel_mag} - (MW+1)'(OFFSET);
        mag_out   = diff[MW] ? '0 : diff[MW-1:0];
        out_msg   = {sgn_acc ^ sign_r[cnt], mag_out};
        out_index = cnt;
        out_last  = cnt_last;
      end
      default: in_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_check_node_minsum_serial.sv
// Testbench for check_node_minsum_serial: two instances (OFFSET=0 and
// OFFSET=1), directed stimulus, expected outputs queued per instance and
// popped by a monitor on every output handshake.
module tb_check_node_minsum_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [6:0] in_msg    [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [6:0] out_msg   [2];
  logic [1:0] out_index [2];
  logic       out_last  [2];

  int errors = 0;
  int checks = 0;

  // {msg[6:0], index[1:0], last}
  logic [9:0] q0 [$];
  logic [9:0] q1 [$];

  always #5 clk = ~clk;

  check_node_minsum_serial #(.DEG(4), .IDXW(2), .MW(6), .OFFSET(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_msg(in_msg[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_msg(out_msg[0]),
    .out_index(out_index[0]), .out_last(out_last[0])
  );

  check_node_minsum_serial #(.DEG(4), .IDXW(2), .MW(6), .OFFSET(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_msg(in_msg[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_msg(out_msg[1]),
    .out_index(out_index[1]), .out_last(out_last[1])
  );

  // Monitor: samples 1 time unit after the falling edge, after stimulus
  // for the coming rising edge has settled.
  always begin
    logic [9:0] exp;
    @(negedge clk);
    #1;
    if (rst_n && out_valid[0] && out_ready[0]) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL out0_unexpected actual msg=%h idx=%0d last=%0d required no output",
                 out_msg[0], out_index[0], out_last[0]);
      end else begin
        exp = q0.pop_front();
        if ({out_msg[0], out_index[0], out_last[0]} !== exp) begin
          errors++;
          $display("FAIL out0 actual msg=%h idx=%0d last=%0d required msg=%h idx=%0d last=%0d",
                   out_msg[0], out_index[0], out_last[0], exp[9:3], exp[2:1], exp[0]);
        end
      end
    end
    if (rst_n && out_valid[1] && out_ready[1]) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL out1_unexpected actual msg=%h idx=%0d last=%0d required no output",
                 out_msg[1], out_index[1], out_last[1]);
      end else begin
        exp = q1.pop_front();
        if ({out_msg[1], out_index[1], out_last[1]} !== exp) begin
          errors++;
          $display("FAIL out1 actual msg=%h idx=%0d last=%0d required msg=%h idx=%0d last=%0d",
                   out_msg[1], out_index[1], out_last[1], exp[9:3], exp[2:1], exp[0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect4(input int d, input logic [6:0] a, input logic [6:0] b,
                         input logic [6:0] c, input logic [6:0] e);
    logic [6:0] v [4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = e;
    for (int i = 0; i < 4; i++) begin
      if (d == 0) q0.push_back({v[i], 2'(i), (i == 3)});
      else        q1.push_back({v[i], 2'(i), (i == 3)});
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input int d, input logic [6:0] m);
    bit done;
    done = 1'b0;
    in_valid[d] = 1'b1;
    in_msg[d]   = m;
    for (int k = 0; k < 40 && !done; k++) begin
      if (in_ready[d]) done = 1'b1;
      @(negedge clk);
    end
    in_valid[d] = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout dut%0d actual in_ready=0 required 1", d);
    end
  endtask

  task automatic send4(input int d, input logic [6:0] a, input logic [6:0] b,
                       input logic [6:0] c, input logic [6:0] e);
    send(d, a); send(d, b); send(d, c); send(d, e);
  endtask

  task automatic drain;
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      if (q0.size() == 0 && q1.size() == 0) ok = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_timeout actual pending=%0d required 0", q0.size() + q1.size());
    end
  endtask

  task automatic check_idle(input int d, input string tag);
    check({tag, "_out_valid"}, 32'(out_valid[d]), 32'd0);
    check({tag, "_out_msg"},   32'(out_msg[d]),   32'd0);
    check({tag, "_out_index"}, 32'(out_index[d]), 32'd0);
    check({tag, "_out_last"},  32'(out_last[d]),  32'd0);
    check({tag, "_in_ready"},  32'(in_ready[d]),  32'd1);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0; in_msg[d] = '0; out_ready[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_idle(0, "reset0");
    check_idle(1, "reset1");

    // T1 basic
    expect4(0, 7'h02, 7'h42, 7'h02, 7'h43);
    send4(0, 7'h05, 7'h43, 7'h07, 7'h42);
    drain();

    // T2 all-equal magnitudes
    expect4(0, 7'h04, 7'h04, 7'h04, 7'h04);
    send4(0, 7'h04, 7'h04, 7'h04, 7'h04);
    drain();

    // T3 backpressure at index 1
    expect4(0, 7'h02, 7'h42, 7'h02, 7'h43);
    send4(0, 7'h05, 7'h43, 7'h07, 7'h42);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (out_valid[0] && out_index[0] == 2'd1) found = 1'b1;
      else @(negedge clk);
    end
    check("t3_reach_idx1", 32'(found), 32'd1);
    out_ready[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_hold_valid", 32'(out_valid[0]), 32'd1);
      check("t3_hold_msg",   32'(out_msg[0]),   32'h42);
      check("t3_hold_index", 32'(out_index[0]), 32'd1);
    end
    out_ready[0] = 1'b1;
    drain();

    // T4 reset after two accepted inputs, then T1 again
    send(0, 7'h41);
    send(0, 7'h40);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle(0, "t4_rst");
    rst_n = 1'b1;
    expect4(0, 7'h02, 7'h42, 7'h02, 7'h43);
    send4(0, 7'h05, 7'h43, 7'h07, 7'h42);
    drain();

    // T5 OFFSET=1 instance
    expect4(1, 7'h01, 7'h41, 7'h01, 7'h42);
    send4(1, 7'h05, 7'h43, 7'h07, 7'h42);
    drain();
    expect4(1, 7'h40, 7'h00, 7'h40, 7'h40);
    send4(1, 7'h00, 7'h40, 7'h00, 7'h00);
    drain();

    // T6 max magnitude, in_valid held high throughout EMIT
    expect4(0, 7'h7F, 7'h3F, 7'h7F, 7'h7F);
    send4(0, 7'h3F, 7'h7F, 7'h3F, 7'h3F);
    in_valid[0] = 1'b1;
    in_msg[0]   = 7'h01;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      check("t6_in_ready_emit", 32'(in_ready[0]), 32'd0);
      if (out_valid[0] && out_ready[0] && out_last[0]) found = 1'b1;
      else @(negedge clk);
    end
    in_valid[0] = 1'b0;
    check("t6_reach_last", 32'(found), 32'd1);
    drain();

    // Follow-up node proves no stray accepts happened during EMIT
    expect4(0, 7'h02, 7'h42, 7'h02, 7'h43);
    send4(0, 7'h05, 7'h43, 7'h07, 7'h42);
    drain();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
